// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch/clock BCD time fields.
//   state_t     : FSM encodings reported on the field's state output
//   bcd_t       : one BCD digit
//   mod_legal   : true when a field modulus lies in 2..100
//   bcd_add_mod : adds a constant step to a two-digit BCD value modulo a
//                 modulus, working digit by digit in BCD
package cronometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_ADJ  = 2'b10
  } state_t;

  typedef logic [3:0] bcd_t;

  function automatic bit mod_legal(input int m);
    return (m >= 2) && (m <= 100);
  endfunction

  // Both the value and the step stay below the modulus, so the raw sum never
  // exceeds 2*modulus-2 (at most 198).
  // A single conditional BCD subtraction of the modulus is therefore enough.
  // The tens digit needs 5 bits only while the sum is still unreduced.
  function automatic logic [7:0] bcd_add_mod(input bcd_t tens, input bcd_t units,
                                             input int step, input int modulus);
    logic [4:0] su;
    logic [4:0] st;
    logic [4:0] mu;
    logic [4:0] mt;
    logic [4:0] us;
    logic [4:0] ts;
    logic       c;
    su = 5'(step % 10);
    st = 5'(step / 10);
    mu = 5'(modulus % 10);
    mt = 5'(modulus / 10);
    us = {1'b0, units} + su;
    c  = 1'b0;
    if (us > 5'd9) begin
      us = us - 5'd10;
      c  = 1'b1;
    end
    ts = {1'b0, tens} + st + {4'd0, c};
    if ((ts > mt) || ((ts == mt) && (us >= mu))) begin
      if (us < mu) begin
        us = us + 5'd10 - mu;
        ts = ts - mt - 5'd1;
      end else begin
        us = us - mu;
        ts = ts - mt;
      end
    end
    return {ts[3:0], us[3:0]};
  endfunction

endpackage

// File: rtl/cronometro_campo_bcd_buton_tekrar.sv
// Adjust-button conditioner: rising-edge detect plus an auto-repeat hold counter.
//   clk, rst : clock and synchronous active-high reset
//   enable   : high while the field is in ADJ; low clears the hold counter
//   btn      : synchronised raw button level
//   cin      : field tick; the hold counter counts these pulses
//   step     : one-cycle pulse requesting a step (edge or repeat)
//   rpt      : qualifies step as an auto-repeat step rather than the first press
module buton_tekrar #(
  parameter int REPEAT_DLY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic btn,
  input  logic cin,
  output logic step,
  output logic rpt
);

  localparam int  CW     = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);
  localparam bit  RPT_ON = (REPEAT_DLY > 0);
  localparam int  THR    = RPT_ON ? REPEAT_DLY - 1 : 0;

  logic          prev;
  logic [CW-1:0] hold_cnt;
  logic          rise;
  logic          held;

  assign rise = btn & ~prev;
  assign held = btn & prev;

  // The edge detector keeps tracking the button outside ADJ, so a button
  // already held when ADJ is entered does not produce a spurious step.
  // The hold counter restarts at the press and saturates at REPEAT_DLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      prev <= btn;
      if (!enable || !btn || rise) begin
        hold_cnt <= '0;
      end else if (cin && (hold_cnt < CW'(REPEAT_DLY))) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // The pulse that brings the counter up to REPEAT_DLY is itself the first
  // repeat step, hence the comparison against REPEAT_DLY-1.
  assign rpt  = RPT_ON && enable && held && cin && (hold_cnt >= CW'(THR));
  assign step = (enable & rise) | rpt;

endmodule

// File: rtl/cronometro_campo_bcd.sv
// One BCD time field (seconds, minutes or hours digit pair) with run/stop/adjust.
//   clk, rst   : clock and synchronous active-high reset
//   cin        : count tick (prescaler or previous field's carry)
//   start_stop : pulse toggling IDLE/RUN
//   clr        : level, clears the value without changing state
//   adj_mode   : level, requests ADJ from IDLE; dropping it leaves ADJ
//   inc, dec   : adjust buttons, already synchronised
//   units,tens : BCD value, always below MOD
//   carry      : one-cycle pulse after a wrap while running
//   state      : current FSM state for the display blink logic
module cronometro_campo_bcd
  import cronometro_pkg::*;
#(
  parameter int MOD        = 60,
  parameter int REPEAT_DLY = 8,
  parameter int STEP_RPT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       adj_mode,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       carry,
  output logic [1:0] state
);

  if (!mod_legal(MOD) || (STEP_RPT < 1) || (STEP_RPT > MOD - 1)) begin : g_param_check
    $error("cronometro_campo_bcd: MOD must be 2..100 and STEP_RPT 1..MOD-1");
  end

  localparam bcd_t MAX_T = bcd_t'((MOD - 1) / 10);
  localparam bcd_t MAX_U = bcd_t'((MOD - 1) % 10);

  state_t     cur;
  state_t     nxt;
  logic       in_adj;
  logic       inc_step;
  logic       inc_rpt;
  logic       dec_step;
  logic       dec_rpt;
  logic [7:0] inc_val;
  logic [7:0] dec_val;
  logic [7:0] val_nxt;
  logic       carry_nxt;

  assign in_adj = (cur == ST_ADJ);
  assign state  = cur;

  buton_tekrar #(.REPEAT_DLY(REPEAT_DLY)) u_inc (
    .clk(clk), .rst(rst), .enable(in_adj), .btn(inc), .cin(cin),
    .step(inc_step), .rpt(inc_rpt)
  );

  buton_tekrar #(.REPEAT_DLY(REPEAT_DLY)) u_dec (
    .clk(clk), .rst(rst), .enable(in_adj), .btn(dec), .cin(cin),
    .step(dec_step), .rpt(dec_rpt)
  );

  // Down-stepping is a modular add of the complement, so one adder serves both.
  assign inc_val = inc_rpt ? bcd_add_mod(tens, units, STEP_RPT, MOD)
                           : bcd_add_mod(tens, units, 1, MOD);
  assign dec_val = dec_rpt ? bcd_add_mod(tens, units, MOD - STEP_RPT, MOD)
                           : bcd_add_mod(tens, units, MOD - 1, MOD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur <= ST_IDLE;
    else     cur <= nxt;
  end

  // Next state. The unused encoding 11 falls back to IDLE.
  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE: begin
        if (start_stop)    nxt = ST_RUN;
        else if (adj_mode) nxt = ST_ADJ;
      end
      ST_RUN: if (start_stop) nxt = ST_IDLE;
      ST_ADJ: if (!adj_mode)  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Value update uses the state before any transition in this cycle.
  // A step with the other button held is suppressed, which also covers
  // simultaneous presses.
  always_comb begin
    val_nxt   = {tens, units};
    carry_nxt = 1'b0;
    if (clr) begin
      val_nxt = 8'h00;
    end else if ((cur == ST_RUN) && cin) begin
      val_nxt   = bcd_add_mod(tens, units, 1, MOD);
      carry_nxt = (tens == MAX_T) && (units == MAX_U);
    end else if (in_adj) begin
      if (inc_step && !dec)      val_nxt = inc_val;
      else if (dec_step && !inc) val_nxt = dec_val;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      units <= 4'd0;
      tens  <= 4'd0;
      carry <= 1'b0;
    end else begin
      tens  <= val_nxt[7:4];
      units <= val_nxt[3:0];
      carry <= carry_nxt;
    end
  end

endmodule

// File: doc/cronometro_campo_bcd.md
Name: cronometro_campo_bcd

Overview:
- Parametrised BCD time field (seconds/minutes/hours digit pair) for the stopwatch/clock datapath.
- Replaces the per-flip-flop set/reset adjust logic with one synchronous counter that has run/stop/adjust modes.
- Adds a generic modulus, up/down adjust with auto-repeat, clear, and a carry output for chaining fields.
- Sits between the tick prescaler (or the previous field's carry) and the display mux.

Parameters:
- MOD, 60, field modulus; legal range 2..100; value counts 0..MOD-1.
- REPEAT_DLY, 8, number of cin pulses an adjust button must be held before auto-repeat starts; 0 disables auto-repeat.
- STEP_RPT, 1, step size per cin pulse during auto-repeat; legal range 1..MOD-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cin  in  1  count enable: prescaler tick for the lowest field, upstream carry for higher fields; one clk wide
- start_stop  in  1  single-cycle pulse; toggles RUN/IDLE
- clr  in  1  level; forces value to 0
- adj_mode  in  1  level; requests ADJ mode
- inc  in  1  level, raw button (already synchronised); adjust up
- dec  in  1  level, raw button (already synchronised); adjust down
- units  out  4  BCD units digit, 0..9
- tens  out  4  BCD tens digit, 0..(MOD-1)/10
- carry  out  1  one-cycle pulse on wrap in RUN
- state  out  2  current FSM state, for display blink logic

Behaviour:
- All outputs are registered.
- Reset: units=0, tens=0, carry=0, state=IDLE, edge/repeat trackers cleared. rst has priority over every other input.
- FSM states: IDLE=00, RUN=01, ADJ=10. Encoding 11 is unreachable; if entered, the next state is IDLE.
- IDLE:
  - start_stop → RUN.
  - Otherwise adj_mode=1 → ADJ.
  - If both are asserted, start_stop wins.
- RUN:
  - start_stop → IDLE.
  - adj_mode, inc and dec are ignored.
- ADJ:
  - adj_mode=0 → IDLE.
  - start_stop is ignored.
- clr: in any state, value:=0 on the next edge. The state is unchanged. clr overrides counting and adjust in the same cycle, and carry is not asserted.
- RUN counting:
  - On an edge where cin=1, the value increments.
  - If value==MOD-1, the value wraps to 0 and carry=1 for exactly the following cycle.
  - The value is visible on the outputs one clk after cin is sampled.
  - A start_stop pulse arriving in the same cycle as cin: the count still happens, using the pre-transition state (RUN).
- ADJ stepping:
  - inc/dec are edge detected internally. A rising edge of inc gives +1 mod MOD; a rising edge of dec gives −1 mod MOD (0 → MOD-1).
  - Rising edges of inc and dec in the same cycle: no change. While inc and dec are both held: no stepping.
  - ADJ never asserts carry; adjusting never ripples into the next field.
- Auto-repeat:
  - A held button's hold counter counts cin pulses, starting from the rising edge.
  - Once the counter reaches REPEAT_DLY, every further cin pulse steps by STEP_RPT, mod MOD, in the held direction.
  - Release, or leaving ADJ, clears the counter.
  - The hold counter saturates; it never wraps.
- Arithmetic: the value is held directly as BCD.
  - Increment carries units 9→0 into tens.
  - Wrap is detected against the BCD constants derived from MOD.
  - Subtraction by STEP_RPT uses modular add of MOD-STEP_RPT. No intermediate exceeds 2·MOD-1.
- Digit ranges: units ≤ 9 and value < MOD always hold. Assertions in the bench check both.
- Leaving ADJ mid-hold: no further steps. The value is retained.

Decomposition:
- Package cronometro_pkg:
  - State encodings ST_IDLE, ST_RUN, ST_ADJ.
  - BCD digit type (4-bit).
  - MOD legality check function.
  - BCD add-mod function shared with future hour/day fields.
- Sub-module buton_tekrar, instantiated twice (inc, dec):
  - Performs the rising-edge detect and the hold counter.
  - Outputs a single step pulse.
  - Parameters: REPEAT_DLY.

Test Plan:
- MOD=60, RUN, 60 cin pulses from 0 → value 00 after the last pulse; carry high exactly once, in the cycle after the 60th pulse; 59→00 transition observed.
- MOD=24, start from 23 in RUN, one cin → tens=0, units=0, carry=1 for one cycle; separately 09→10 on one cin.
- ADJ, value 00, single dec edge → 59 (MOD=60), no carry; inc and dec rising together → value unchanged.
- ADJ, hold inc with REPEAT_DLY=8 over 12 cin pulses from 05 → 06 after the edge, stays 06 through pulse 7, then 07,08,09,10,11 on pulses 8–12; release → no further change.
- RUN at 37 with clr and cin asserted in the same cycle → 00, carry=0, state stays RUN; rst asserted mid-ADJ hold → all outputs 0, state IDLE next cycle.
- IDLE with start_stop and adj_mode together → RUN; in RUN, inc edges → no change.
